instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 24 ++
 rtl/instr_loader.sv | 80 ++++++++
 tb/tb_instr_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// instr_loader_if: control, byte-stream and instruction-memory write signals of instr_loader
interface instr_loader_if;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output start, base_addr, word_count, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
  modport slave (
    input  start, base_addr, word_count, abort, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory
module instr_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic         clk,
  input logic         rst,
  instr_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t      state;
  logic [31:0] addr;
  logic [23:0] asm_r;
  logic [15:0] remaining;
  logic [15:0] idle;
  logic [1:0]  idx;
  logic        err;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        accept;
  assign accept       = bus.in_valid && state == RECV;
  assign bus.in_ready = state == RECV;
  assign bus.busy     = state != IDLE;
  assign bus.wr_en    = state == WRITE && !bus.abort;
  assign bus.done     = state == DONE && !bus.abort;
  assign bus.err      = err;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      asm_r     <= '0;
      remaining <= '0;
      idle      <= '0;
      idx       <= '0;
      err       <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (bus.abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          err <= 1'b0;
          if (bus.word_count != 16'd0) begin
            addr      <= bus.base_addr;
            remaining <= bus.word_count;
            idx       <= '0;
            idle      <= '0;
            state     <= RECV;
          end else begin
            state <= DONE;
          end
        end
        RECV: if (accept) begin
          asm_r <= {asm_r[15:0], bus.in_data};
          idx   <= idx + 2'd1;
          idle  <= '0;
          if (idx == 2'd3) begin
            wr_addr <= addr;
            wr_data <= {asm_r, bus.in_data};
            state   <= WRITE;
          end
        end else if (idle == 16'(TIMEOUT_CYCLES - 1)) begin
          err   <= 1'b1;
          state <= IDLE;
        end else begin
          idle <= idle + 16'd1;
        end
        WRITE: begin
          addr      <= addr + 32'd4;
          remaining <= remaining - 16'd1;
          idle      <= '0;
          state     <= remaining == 16'd1 ? DONE : RECV;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader with directed byte streams
module tb_instr_loader;
  typedef struct {
    bit          is_done;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  int wr_times[$];
  instr_loader_if bus();
  instr_loader #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_done = 1'b0;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask
  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.a = '0;
    e.d = '0;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.wr_en) begin
        wr_times.push_back(cyc);
        if (q.size() != 0 && !q[0].is_done) begin
          e = q.pop_front();
          chk("wr_addr", bus.wr_addr, e.a);
          chk("wr_data", bus.wr_data, e.d);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.wr_addr, bus.wr_data);
        end
      end
      if (bus.done) begin
        if (q.size() != 0 && q[0].is_done) begin
          e = q.pop_front();
          chk("done_pulse", {31'd0, bus.done}, 32'd1);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (queue %0d)", q.size());
        end
      end
    end
  end
  task automatic do_start(input logic [31:0] a, input logic [15:0] wc);
    bus.start = 1'b1;
    bus.base_addr = a;
    bus.word_count = wc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got in_ready=0 for 50 cycles expected acceptance of %h", b);
    end
  endtask
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask
  task automatic wait_idle(input string n);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.busy && q.size() == 0;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_idle: got busy=%0b pending=%0d expected idle and empty", n, bus.busy, q.size());
    end
  endtask
  initial begin
    int gaps[8] = '{0, 2, 5, 1, 6, 3, 0, 4};
    logic [31:0] w;
    bus.start = 0;
    bus.base_addr = 0;
    bus.word_count = 0;
    bus.abort = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    #1 rst = 1'b0;
    // back-to-back stream; a stray start mid-load must be ignored
    push_wr(32'h100, 32'h13000093);
    push_wr(32'h104, 32'h00100013);
    push_done();
    wr_times.delete();
    do_start(32'h100, 16'd2);
    bus.start = 1'b1;
    bus.base_addr = 32'hBAD0;
    bus.word_count = 16'd7;
    send_word(32'h13000093, 0);
    bus.start = 1'b0;
    send_word(32'h00100013, 0);
    wait_idle("s1");
    chk("s1_nwrites", wr_times.size(), 2);
    if (wr_times.size() == 2) chk("s1_throughput", wr_times[1] - wr_times[0], 5);
    // gapped stream, gaps below the timeout
    push_wr(32'h100, 32'h13000093);
    push_wr(32'h104, 32'h00100013);
    push_done();
    do_start(32'h100, 16'd2);
    for (int i = 0; i < 4; i++) send_byte(8'(32'h13000093 >> (24 - 8*i)), gaps[i]);
    for (int i = 0; i < 4; i++) send_byte(8'(32'h00100013 >> (24 - 8*i)), gaps[i+4]);
    wait_idle("s2");
    chk("s2_err", {31'd0, bus.err}, 0);
    // timeout after two bytes: 8 idle RECV cycles
    do_start(32'h500, 16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("to_err_early", {31'd0, bus.err}, 0);
    chk("to_busy_early", {31'd0, bus.busy}, 1);
    @(negedge clk);
    chk("to_err", {31'd0, bus.err}, 1);
    chk("to_busy", {31'd0, bus.busy}, 0);
    chk("to_in_ready", {31'd0, bus.in_ready}, 0);
    #1 push_done();
    do_start(32'h0, 16'd0);
    @(negedge clk);
    chk("to_err_cleared", {31'd0, bus.err}, 0);
    wait_idle("to");
    // address wrap
    push_wr(32'hFFFFFFFC, 32'h01020304);
    push_wr(32'h00000000, 32'hA5A55A5A);
    push_done();
    do_start(32'hFFFFFFFC, 16'd2);
    send_word(32'h01020304, 0);
    send_word(32'hA5A55A5A, 1);
    wait_idle("wrap");
    // abort on the WRITE cycle
    do_start(32'h200, 16'd1);
    send_word(32'hCAFEF00D, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("ab_wr_en", {31'd0, bus.wr_en}, 0);
    chk("ab_busy_write", {31'd0, bus.busy}, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ab_busy_after", {31'd0, bus.busy}, 0);
    chk("ab_done", {31'd0, bus.done}, 0);
    // abort together with start in IDLE: start wins, zero-count load pulses done
    push_done();
    do_start(32'h0, 16'd0);
    bus.abort = 1'b0;
    wait_idle("zero");
    // reset mid-word, then a fresh load
    do_start(32'h300, 16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mr_in_ready", {31'd0, bus.in_ready}, 0);
    chk("mr_busy", {31'd0, bus.busy}, 0);
    chk("mr_wr_en", {31'd0, bus.wr_en}, 0);
    chk("mr_done", {31'd0, bus.done}, 0);
    chk("mr_wr_addr", bus.wr_addr, 0);
    chk("mr_wr_data", bus.wr_data, 0);
    chk("mr_err", {31'd0, bus.err}, 0);
    #1 rst = 1'b0;
    w = 32'hDEADBEEF;
    push_wr(32'h40, w);
    push_done();
    do_start(32'h40, 16'd1);
    send_word(w, 0);
    wait_idle("fresh");
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
